// File: rtl/crg_stream_if.sv
// -----------------------------------------------------------------------------
// crg_stream_if
//   Bundles every non-clock signal of the crg_stream controller.
//   slave  : the controller's view (crg_stream)
//   master : the surrounding system's view (control, generator pipeline,
//            consumer) -- used by the testbench
//   Control    : start_i, abort_i, cnt_start_i, cnt_end_i
//   Generator  : issue_o, cnt_o (out), gen_vld_i, gen_a_i/b_i/c_i (in)
//   Stream     : valid_o, a_o/b_o/c_o (out), ready_i (in)
//   Status     : level_o, busy_o, done_o, aborted_o, err_o
// -----------------------------------------------------------------------------
interface crg_stream_if #(
  parameter int W     = 256,
  parameter int CNT_W = 64,
  parameter int DEPTH = 32,
  parameter int LVL_W = $clog2(DEPTH + 1)
);
  logic             start_i;
  logic             abort_i;
  logic [CNT_W-1:0] cnt_start_i;
  logic [CNT_W-1:0] cnt_end_i;

  logic             issue_o;
  logic [CNT_W-1:0] cnt_o;
  logic             gen_vld_i;
  logic [W-1:0]     gen_a_i;
  logic [W-1:0]     gen_b_i;
  logic [W-1:0]     gen_c_i;

  logic             valid_o;
  logic [W-1:0]     a_o;
  logic [W-1:0]     b_o;
  logic [W-1:0]     c_o;
  logic             ready_i;

  logic [LVL_W-1:0] level_o;
  logic             busy_o;
  logic             done_o;
  logic             aborted_o;
  logic             err_o;

  modport slave (
    input  start_i, abort_i, cnt_start_i, cnt_end_i,
    output issue_o, cnt_o,
    input  gen_vld_i, gen_a_i, gen_b_i, gen_c_i,
    output valid_o, a_o, b_o, c_o,
    input  ready_i,
    output level_o, busy_o, done_o, aborted_o, err_o
  );

  modport master (
    output start_i, abort_i, cnt_start_i, cnt_end_i,
    input  issue_o, cnt_o,
    output gen_vld_i, gen_a_i, gen_b_i, gen_c_i,
    input  valid_o, a_o, b_o, c_o,
    output ready_i,
    input  level_o, busy_o, done_o, aborted_o, err_o
  );
endinterface

// File: rtl/crg_stream.sv
// -----------------------------------------------------------------------------
// crg_stream
//   Issue/collect controller for the Beaver-triple datapath. Walks the
//   counter range [cnt_start_i .. cnt_end_i] (wrapping modulo 2^CNT_W), issues
//   one counter per cycle to the external fixed-latency generator pipeline,
//   and buffers the returned (a, b, c) triples in a first-word-fall-through
//   FIFO presented as a valid/ready stream. Issue is credit based:
//   in_flight + level never exceeds DEPTH, so the FIFO cannot overflow no
//   matter how long the consumer stalls.
//
//   Ports:
//     clk_i    clock
//     rst_n_i  asynchronous active-low reset
//     bus      crg_stream_if.slave (control, generator, stream, status)
// -----------------------------------------------------------------------------
module crg_stream #(
  parameter int W     = 256,
  parameter int CNT_W = 64,
  parameter int DEPTH = 32,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  crg_stream_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int SUM_W  = LVL_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [SUM_W-1:0] CREDIT   = SUM_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_e;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } triple_t;

  state_e           state_q;
  logic [CNT_W-1:0] cur_q;
  logic [CNT_W-1:0] end_q;
  logic [CNT_W-1:0] cnt_q;
  logic             issue_q;
  logic             done_q;
  logic             aborted_q;
  logic             err_q,       err_d;
  logic [LVL_W-1:0] in_flight_q, in_flight_d;
  logic [LVL_W-1:0] level_q,     level_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  triple_t          mem_q [DEPTH];
  triple_t          head;

  logic valid;
  logic full;
  logic credit_ok;
  logic issue_now;
  logic flush_now;
  logic ret;
  logic accept;
  logic push;
  logic pop;

  // Credit uses registered counts only: an issue this cycle can never push
  // in_flight + level past DEPTH.
  assign credit_ok = ({1'b0, in_flight_q} + {1'b0, level_q}) < CREDIT;
  assign valid     = (level_q != '0);
  assign full      = (level_q == LVL_FULL);
  assign pop       = valid & bus.ready_i;
  // A return is only genuine if something is outstanding.
  assign ret       = bus.gen_vld_i & (in_flight_q != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    issue_now = 1'b0;
    flush_now = 1'b0;
    case (state_q)
      S_IDLE:  issue_now = bus.start_i;
      S_RUN: begin
        flush_now = bus.abort_i;
        issue_now = ~bus.abort_i & credit_ok;
      end
      S_DRAIN: flush_now = bus.abort_i;
      default: ;
    endcase

    // Returns are dropped while flushing (including the abort cycle itself).
    accept = ret & ~flush_now & (state_q != S_FLUSH);
    push   = accept & (~full | pop);

    err_d = err_q
          | (bus.gen_vld_i & (in_flight_q == '0))
          | (accept & full & ~pop);

    in_flight_d = in_flight_q + LVL_W'(issue_now) - LVL_W'(ret);

    if (flush_now) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end
  end

  // Control FSM with registered issue/cnt/done/aborted outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      end_q     <= '0;
      cnt_q     <= '0;
      issue_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      issue_q   <= issue_now;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            // The first counter goes out on the accepting edge itself.
            cnt_q   <= bus.cnt_start_i;
            cur_q   <= bus.cnt_start_i + CNT_ONE;
            end_q   <= bus.cnt_end_i;
            state_q <= (bus.cnt_start_i == bus.cnt_end_i) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (bus.abort_i) begin
            state_q <= S_FLUSH;
          end else if (issue_now) begin
            cnt_q <= cur_q;
            cur_q <= cur_q + CNT_ONE;
            if (cur_q == end_q) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.abort_i) begin
            state_q <= S_FLUSH;
          end else if (in_flight_d == '0 && level_d == '0) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_FLUSH: begin
          if (in_flight_d == '0) begin
            aborted_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping, in-flight tracking and sticky error.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_flight_q <= '0;
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
    end
  end

  // NOTE: the storage array has no reset; level/pointers define what is
  // valid and the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{a: bus.gen_a_i, b: bus.gen_b_i, c: bus.gen_c_i};
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.issue_o   = issue_q;
  assign bus.cnt_o     = cnt_q;
  assign bus.valid_o   = valid;
  assign bus.a_o       = valid ? head.a : '0;
  assign bus.b_o       = valid ? head.b : '0;
  assign bus.c_o       = valid ? head.c : '0;
  assign bus.level_o   = level_q;
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.done_o    = done_q;
  assign bus.aborted_o = aborted_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_crg_stream.sv
// -----------------------------------------------------------------------------
// tb_crg_stream
//   Drives crg_stream through its interface with a fixed-latency generator
//   pipeline model. Expected counters/triples are queued when a range is
//   started; a negedge monitor collects what the DUT issues and delivers, and
//   each test task pops and compares.
// -----------------------------------------------------------------------------
module tb_crg_stream;

  localparam int W       = 256;
  localparam int CNT_W   = 64;
  localparam int DEPTH   = 32;
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int MAX_LAT = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
  } trip_t;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   lat      = 27;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  crg_stream_if #(.W(W), .CNT_W(CNT_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) bus ();

  crg_stream #(.W(W), .CNT_W(CNT_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  // Triple the generator returns for a counter: distinct per field so
  // swapped shares or reordered entries are visible.
  function automatic trip_t mk(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] nc;
    trip_t t;
    nc  = ~c;
    t.a = W'(c);
    t.b = W'(nc) << CNT_W;
    t.c = W'(c) << (W - CNT_W);
    return t;
  endfunction

  // ---------------- generator pipeline model ----------------
  logic             pv [MAX_LAT];
  logic [CNT_W-1:0] pc [MAX_LAT];
  logic             inj_vld = 1'b0;
  logic [CNT_W-1:0] inj_cnt = '0;

  initial begin
    for (int i = 0; i < MAX_LAT; i++) begin
      pv[i] = 1'b0;
      pc[i] = '0;
    end
  end

  always @(negedge clk_i) begin : model
    trip_t            t;
    logic [CNT_W-1:0] c;
    logic             v;
    v = pv[lat-1] | inj_vld;
    c = inj_vld ? inj_cnt : pc[lat-1];
    t = mk(c);
    for (int i = MAX_LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pc[i] = pc[i-1];
    end
    pv[0] = bus.issue_o;
    pc[0] = bus.cnt_o;
    if (!rst_n_i) begin
      for (int i = 0; i < MAX_LAT; i++) pv[i] = 1'b0;
      v = 1'b0;
    end
    bus.gen_vld_i = v;
    bus.gen_a_i   = t.a;
    bus.gen_b_i   = t.b;
    bus.gen_c_i   = t.c;
  end

  // ---------------- scoreboard ----------------
  logic [CNT_W-1:0] exp_c [$];
  trip_t            exp_t [$];
  logic [CNT_W-1:0] obs_c [$];
  int               obs_cyc [$];
  trip_t            obs_t [$];
  int               done_cnt  = 0;
  int               abort_cnt = 0;

  always @(negedge clk_i) begin : monitor
    if (rst_n_i) begin
      if (bus.issue_o) begin
        obs_c.push_back(bus.cnt_o);
        obs_cyc.push_back(cyc);
      end
      if (bus.valid_o && bus.ready_i) obs_t.push_back('{a: bus.a_o, b: bus.b_o, c: bus.c_o});
      if (bus.done_o)    done_cnt++;
      if (bus.aborted_o) abort_cnt++;
    end
  end

  task automatic clear_sb();
    exp_c.delete();
    exp_t.delete();
    obs_c.delete();
    obs_cyc.delete();
    obs_t.delete();
    done_cnt  = 0;
    abort_cnt = 0;
  endtask

  // Queue expectations for the range, then pulse start_i for one edge.
  // Returns in the cycle right after the accepting edge.
  task automatic start_range(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] e);
    logic [CNT_W-1:0] c;
    c = s;
    for (int n = 0; n < 1000; n++) begin
      exp_c.push_back(c);
      exp_t.push_back(mk(c));
      if (c == e) break;
      c = c + 1;
    end
    @(posedge clk_i); #1;
    bus.start_i     = 1'b1;
    bus.cnt_start_i = s;
    bus.cnt_end_i   = e;
    @(posedge clk_i); #1;
    bus.start_i     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (!bus.busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk_i);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++; if (bus.issue_o !== 1'b0) begin failures++; $display("FAIL reset_issue got=%b exp=0", bus.issue_o); end
    checks++; if (bus.cnt_o !== '0)     begin failures++; $display("FAIL reset_cnt got=%h exp=0", bus.cnt_o); end
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.level_o !== '0)   begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level_o); end
    checks++; if ({bus.busy_o, bus.done_o, bus.aborted_o, bus.err_o} !== 4'b0)
      begin failures++; $display("FAIL reset_status got=%b exp=0000", {bus.busy_o, bus.done_o, bus.aborted_o, bus.err_o}); end
    checks++; if ((bus.a_o | bus.b_o | bus.c_o) !== '0) begin failures++; $display("FAIL reset_data got=nonzero exp=0"); end
    @(negedge clk_i); #2;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_basic();
    bit ok;
    trip_t e;
    trip_t o;
    clear_sb();
    bus.ready_i = 1'b1;
    start_range(64'd5, 64'd9);
    checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy_o); end
    checks++; if (bus.issue_o !== 1'b1 || bus.cnt_o !== 64'd5)
      begin failures++; $display("FAIL basic_first_issue got=%b/%h exp=1/5", bus.issue_o, bus.cnt_o); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=busy exp=idle"); end
    checks++; if (obs_c.size() != 5) begin failures++; $display("FAIL basic_issue_count got=%0d exp=5", obs_c.size()); end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] != obs_cyc[0] + i) begin failures++; $display("FAIL basic_issue_gap[%0d] got=%0d exp=%0d", i, obs_cyc[i], obs_cyc[0] + i); end
    end
    while (exp_c.size() > 0) begin
      logic [CNT_W-1:0] ec;
      ec = exp_c.pop_front();
      checks++;
      if (obs_c.size() == 0) begin failures++; $display("FAIL basic_cnt got=none exp=%h", ec); end
      else begin
        logic [CNT_W-1:0] oc;
        oc = obs_c.pop_front();
        if (oc !== ec) begin failures++; $display("FAIL basic_cnt got=%h exp=%h", oc, ec); end
      end
    end
    while (exp_t.size() > 0) begin
      e = exp_t.pop_front();
      checks++;
      if (obs_t.size() == 0) begin failures++; $display("FAIL basic_triple got=none exp_a=%h", e.a); end
      else begin
        o = obs_t.pop_front();
        if (o !== e) begin failures++; $display("FAIL basic_triple got_a=%h exp_a=%h", o.a, e.a); end
      end
    end
    checks++; if (obs_t.size() != 0) begin failures++; $display("FAIL basic_extra got=%0d exp=0", obs_t.size()); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", bus.err_o); end
  endtask

  task automatic test_wrap();
    bit ok;
    trip_t e;
    trip_t o;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] oc;
    clear_sb();
    bus.ready_i = 1'b1;
    start_range(64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=busy exp=idle"); end
    checks++; if (exp_c.size() != 4) begin failures++; $display("FAIL wrap_expected_len got=%0d exp=4", exp_c.size()); end
    while (exp_c.size() > 0) begin
      ec = exp_c.pop_front();
      checks++;
      if (obs_c.size() == 0) begin failures++; $display("FAIL wrap_cnt got=none exp=%h", ec); end
      else begin
        oc = obs_c.pop_front();
        if (oc !== ec) begin failures++; $display("FAIL wrap_cnt got=%h exp=%h", oc, ec); end
      end
    end
    while (exp_t.size() > 0) begin
      e = exp_t.pop_front();
      checks++;
      if (obs_t.size() == 0) begin failures++; $display("FAIL wrap_triple got=none exp_a=%h", e.a); end
      else begin
        o = obs_t.pop_front();
        if (o !== e) begin failures++; $display("FAIL wrap_triple got_a=%h exp_a=%h", o.a, e.a); end
      end
    end
    checks++; if (obs_t.size() != 0 || done_cnt != 1)
      begin failures++; $display("FAIL wrap_tail got=extra%0d/done%0d exp=0/1", obs_t.size(), done_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit full_seen;
    trip_t e;
    trip_t o;
    clear_sb();
    bus.ready_i = 1'b0;
    start_range(64'd0, 64'd99);
    full_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (bus.level_o == LVL_W'(DEPTH)) begin full_seen = 1'b1; break; end
    end
    checks++; if (!full_seen) begin failures++; $display("FAIL bp_level_full got=%0d exp=%0d", bus.level_o, DEPTH); end
    repeat (20) @(negedge clk_i);
    // Nothing popped yet, so every issued counter sits in the FIFO or in flight.
    checks++; if (obs_c.size() != DEPTH) begin failures++; $display("FAIL bp_outstanding got=%0d exp=%0d", obs_c.size(), DEPTH); end
    checks++; if (bus.issue_o !== 1'b0) begin failures++; $display("FAIL bp_stall_issue got=%b exp=0", bus.issue_o); end
    checks++; if (bus.level_o !== LVL_W'(DEPTH)) begin failures++; $display("FAIL bp_level_hold got=%0d exp=%0d", bus.level_o, DEPTH); end
    @(posedge clk_i); #1;
    bus.ready_i = 1'b1;
    wait_idle(1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=busy exp=idle"); end
    checks++; if (obs_t.size() != 100) begin failures++; $display("FAIL bp_count got=%0d exp=100", obs_t.size()); end
    while (exp_t.size() > 0) begin
      e = exp_t.pop_front();
      checks++;
      if (obs_t.size() == 0) begin failures++; $display("FAIL bp_triple got=none exp_a=%h", e.a); end
      else begin
        o = obs_t.pop_front();
        if (o !== e) begin failures++; $display("FAIL bp_triple got_a=%h exp_a=%h", o.a, e.a); end
      end
    end
    checks++; if (bus.err_o !== 1'b0 || done_cnt != 1)
      begin failures++; $display("FAIL bp_status got=err%b/done%0d exp=err0/done1", bus.err_o, done_cnt); end
  endtask

  task automatic test_abort();
    bit ok;
    bit hit;
    trip_t e;
    trip_t o;
    lat = 8;
    clear_sb();
    bus.ready_i = 1'b0;
    start_range(64'd0, 64'd99);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (bus.level_o == LVL_W'(3)) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL abort_level3 got=%0d exp=3", bus.level_o); end
    bus.abort_i = 1'b1;
    @(posedge clk_i); #1;
    bus.abort_i = 1'b0;
    checks++; if (bus.valid_o !== 1'b0 || bus.level_o !== '0)
      begin failures++; $display("FAIL abort_flush got=valid%b/level%0d exp=valid0/level0", bus.valid_o, bus.level_o); end
    checks++; if (bus.issue_o !== 1'b0) begin failures++; $display("FAIL abort_issue_stop got=%b exp=0", bus.issue_o); end
    bus.ready_i = 1'b1;
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL abort_timeout got=busy exp=idle"); end
    checks++; if (abort_cnt != 1) begin failures++; $display("FAIL abort_pulse got=%0d exp=1", abort_cnt); end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    checks++; if (obs_t.size() != 0) begin failures++; $display("FAIL abort_discard got=%0d exp=0", obs_t.size()); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", bus.err_o); end

    clear_sb();
    start_range(64'd0, 64'd0);
    checks++; if (bus.issue_o !== 1'b1 || bus.cnt_o !== '0)
      begin failures++; $display("FAIL single_issue got=%b/%h exp=1/0", bus.issue_o, bus.cnt_o); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=busy exp=idle"); end
    checks++; if (obs_t.size() != 1 || obs_c.size() != 1)
      begin failures++; $display("FAIL single_count got=%0d/%0d exp=1/1", obs_t.size(), obs_c.size()); end
    while (exp_t.size() > 0) begin
      e = exp_t.pop_front();
      checks++;
      if (obs_t.size() == 0) begin failures++; $display("FAIL single_triple got=none exp_a=%h", e.a); end
      else begin
        o = obs_t.pop_front();
        if (o !== e) begin failures++; $display("FAIL single_triple got_a=%h exp_a=%h", o.a, e.a); end
      end
    end
    checks++; if (done_cnt != 1 || abort_cnt != 0)
      begin failures++; $display("FAIL single_done got=%0d/%0d exp=1/0", done_cnt, abort_cnt); end
    lat = 27;
  endtask

  task automatic test_err();
    @(posedge clk_i); #1;
    inj_vld = 1'b1;
    inj_cnt = 64'h55;
    @(posedge clk_i); #1;
    inj_vld = 1'b0;
    @(posedge clk_i); #1;
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", bus.err_o); end
    checks++; if (bus.level_o !== '0 || bus.valid_o !== 1'b0)
      begin failures++; $display("FAIL err_drop got=level%0d/valid%b exp=level0/valid0", bus.level_o, bus.valid_o); end
    repeat (10) @(posedge clk_i);
    #1;
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", bus.err_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL err_idle got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    trip_t e;
    trip_t o;
    clear_sb();
    bus.ready_i = 1'b1;
    start_range(64'd0, 64'd99);
    repeat (40) @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    checks++; if (bus.issue_o !== 1'b0 || bus.cnt_o !== '0)
      begin failures++; $display("FAIL rst_mid_issue got=%b/%h exp=0/0", bus.issue_o, bus.cnt_o); end
    checks++; if (bus.valid_o !== 1'b0 || bus.level_o !== '0)
      begin failures++; $display("FAIL rst_mid_fifo got=%b/%0d exp=0/0", bus.valid_o, bus.level_o); end
    checks++; if ((bus.a_o | bus.b_o | bus.c_o) !== '0) begin failures++; $display("FAIL rst_mid_data got=nonzero exp=0"); end
    checks++; if ({bus.busy_o, bus.done_o, bus.aborted_o, bus.err_o} !== 4'b0)
      begin failures++; $display("FAIL rst_mid_status got=%b exp=0000", {bus.busy_o, bus.done_o, bus.aborted_o, bus.err_o}); end
    @(negedge clk_i);
    @(negedge clk_i); #2;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.issue_o !== 1'b0)
      begin failures++; $display("FAIL rst_mid_idle got=%b/%b exp=0/0", bus.busy_o, bus.issue_o); end

    clear_sb();
    start_range(64'd3, 64'd4);
    checks++; if (bus.cnt_o !== 64'd3) begin failures++; $display("FAIL post_rst_issue got=%h exp=3", bus.cnt_o); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL post_rst_timeout got=busy exp=idle"); end
    while (exp_t.size() > 0) begin
      e = exp_t.pop_front();
      checks++;
      if (obs_t.size() == 0) begin failures++; $display("FAIL post_rst_triple got=none exp_a=%h", e.a); end
      else begin
        o = obs_t.pop_front();
        if (o !== e) begin failures++; $display("FAIL post_rst_triple got_a=%h exp_a=%h", o.a, e.a); end
      end
    end
    checks++; if (done_cnt != 1 || bus.err_o !== 1'b0)
      begin failures++; $display("FAIL post_rst_status got=done%0d/err%b exp=done1/err0", done_cnt, bus.err_o); end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.cnt_start_i = '0;
    bus.cnt_end_i   = '0;
    bus.ready_i     = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_abort();
    test_err();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crg_stream.md
# crg_stream

Parametrised, back-pressured issue/collect controller for the correlated-random (Beaver-triple) datapath. It walks a counter range and issues one counter per cycle to the external fixed-latency triple-generation pipeline (PRNG cores plus SIMD sub/xor and mul/and stages). It collects the returned (a, b, c) triples in an internal FIFO and presents them on a valid/ready stream. Credit-based issue guarantees the FIFO never overflows, so downstream consumers may stall arbitrarily.

## Interface
Parameters:
- W, 256: width of each triple share (a, b, c).
- CNT_W, 64: counter width.
- DEPTH, 32: FIFO depth in entries; power of two, ≥ 2.
- LVL_W, $clog2(DEPTH+1): width of level/in-flight counters (derived).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- abort_i  in  1  abort request; sampled in RUN and DRAIN.
- cnt_start_i  in  CNT_W  first counter; latched on accepted start.
- cnt_end_i  in  CNT_W  last counter, inclusive; latched on accepted start.
- issue_o  out  1  counter valid to the generator pipeline (registered).
- cnt_o  out  CNT_W  counter issued with issue_o.
- gen_vld_i  in  1  triple returned by the pipeline.
- gen_a_i / gen_b_i / gen_c_i  in  W  returned triple.
- valid_o  out  1  FIFO non-empty.
- a_o / b_o / c_o  out  W  FIFO head (first-word fall-through).
- ready_i  in  1  consumer accepts the head when valid_o is high.
- level_o  out  LVL_W  FIFO occupancy.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse at normal completion.
- aborted_o  out  1  one-cycle pulse at abort completion.
- err_o  out  1  sticky protocol error; cleared only by reset.

## Operation
- States:
  - IDLE: start_i=1 latches the range, loads cur←cnt_start_i, and moves to RUN. While busy, start_i is ignored.
  - RUN: issues while in-flight + level < DEPTH. After issuing cur == end_q, moves to DRAIN.
  - DRAIN: no issue. When in_flight == 0 and the FIFO is empty, pulses done_o and returns to IDLE.
  - FLUSH: entered on abort_i in RUN or DRAIN. Issue stops the same cycle, the FIFO is cleared, and returning gen_vld_i data is discarded until in_flight == 0. Then pulses aborted_o and returns to IDLE.
- Counter:
  - cur increments modulo 2^CNT_W, so a range with cnt_end_i < cnt_start_i wraps through 0.
  - cnt_start_i == cnt_end_i issues exactly one counter.
  - 0 is a legal counter value.
- in_flight:
  - +1 per issue, −1 per gen_vld_i.
  - Issue and return in the same cycle leave it unchanged.
- FIFO:
  - Push on gen_vld_i (outside FLUSH); pop on valid_o & ready_i.
  - Simultaneous push and pop is legal at any level, including full.
  - Order is preserved: triples leave in issue order.
- Errors (err_o set; offending data dropped):
  - gen_vld_i with in_flight == 0.
  - Push into a full FIFO without a simultaneous pop.
- abort_i in IDLE is ignored. abort_i and start_i together in IDLE: start wins.
- Reset values: state IDLE, FIFO empty, in_flight 0, and every output 0 (issue_o, cnt_o, valid_o, a_o/b_o/c_o, level_o, busy_o, done_o, aborted_o, err_o). Asserting reset mid-run discards everything immediately.

## Timing
- start_i accepted at edge k:
  - busy_o = 1 from cycle k+1.
  - First issue_o = 1 with cnt_o = cnt_start_i in cycle k+1.
- Issue rule:
  - Peak rate is one issue per cycle.
  - Credit test uses registered in_flight and level, so at most DEPTH entries are ever outstanding.
  - Full throughput with ready_i=1 requires DEPTH ≥ pipeline latency + 2; smaller DEPTH is legal but throttles.
- Push at edge k makes the data visible on valid_o/a_o/b_o/c_o in cycle k+1.
- level_o updates at the edge of the push/pop.
- Completion:
  - done_o pulses in the cycle after the last pop empties the FIFO with in_flight == 0; busy_o drops in the same cycle.
  - aborted_o pulses the cycle after in_flight reaches 0 in FLUSH.
  - valid_o = 0 from the cycle after abort_i.

## Test plan
- Range 5..9, ready_i=1, 27-cycle pipeline model returning cnt as a/b/c → cnt_o 5,6,7,8,9 on consecutive cycles; outputs 5..9 in order; one done_o pulse; err_o=0.
- Wrap with CNT_W=64, start=2^64−2, end=1 → cnt_o FFFF…FFFE, FFFF…FFFF, 0, 1; four triples delivered.
- ready_i=0, DEPTH=32, range 0..99 → issue stalls with level_o + in_flight = 32 and level_o reaching 32; release ready_i → all 100 delivered in order, err_o stays 0.
- abort_i after 10 issues with 3 in FIFO → valid_o=0 next cycle; in-flight returns discarded; aborted_o pulses once, no done_o; a following start 0..0 delivers exactly one triple.
- gen_vld_i pulsed in IDLE → err_o=1, level_o stays 0, err_o persists until rst_n_i low.
- rst_n_i asserted mid-RUN (asynchronous, between edges) → all outputs 0 immediately; state IDLE after release.
